fifo_pkt_serializer: RTL and testbench

- Consumer end of the 10-bit packet FIFO interface.
- Pops one packet whenever the FIFO is non-empty and the block is free, then shifts it out on a single-wire, UART-style serial line.
- Frame: start bit, 10 data bits LSB-first, optional parity, stop bit.
- Sits directly on the FIFO read port: `empty`/`pkt_in` in, `re` out.

---
 rtl/fifo_pkt_serializer.sv | 132 +++++++++++++
 tb/tb_fifo_pkt_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_serializer.sv
// Pops 10-bit packets from a FWFT FIFO and sends each as a UART-style frame: start, W data LSB-first, [parity], stop.
// Start bit appears the cycle after the pop; back-to-back frames have no idle gap. Defining FIFO_SER_PARITY_EN adds even parity.
module fifo_pkt_serializer #(
   parameter int W        = 10,
   parameter int BAUD_DIV = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             empty,
   input  logic [W-1:0]     pkt_in,
   output logic             re,
   output logic             tx,
   output logic             busy,
   output logic [CNT_W-1:0] pkt_cnt
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int IW = (W > 1) ? $clog2(W) : 1;

`ifdef FIFO_SER_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par_q;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t         state, state_nxt;
   logic [BW-1:0]  baud_cnt;
   logic [IW-1:0]  bit_idx;
   logic [W-1:0]   shreg, shreg_nxt;
   logic           tx_nxt;
   logic           baud_last;
   logic           pop;

   // With one cycle per bit every state ends on every cycle and the counter stays at zero.
   generate
      if (BAUD_DIV == 1) begin : g_div1
         assign baud_last = 1'b1;
      end else begin : g_divn
         assign baud_last = (baud_cnt == BW'(BAUD_DIV - 1));
      end
   endgenerate

   // The FIFO has no underflow guard, so re must never fire while empty or in reset.
   assign pop = rst & en & ~empty & ((state == IDLE) | ((state == STOP) & baud_last));
   assign re  = pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      tx_nxt    = 1'b1;
      case (state)
         IDLE: begin
            if (pop) state_nxt = START;
         end
         START: begin
            if (baud_last) state_nxt = DATA;
         end
         DATA: begin
            if (baud_last) begin
               shreg_nxt = shreg >> 1;
`ifdef FIFO_SER_PARITY_EN
               if (bit_idx == IW'(W - 1)) state_nxt = PARITY;
`else
               if (bit_idx == IW'(W - 1)) state_nxt = STOP;
`endif
            end
         end
`ifdef FIFO_SER_PARITY_EN
         PARITY: begin
            if (baud_last) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (baud_last) state_nxt = pop ? START : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (pop) shreg_nxt = pkt_in;
      // tx is registered, so it is decoded from where the FSM is heading.
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
`ifdef FIFO_SER_PARITY_EN
         PARITY:  tx_nxt = par_q;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         pkt_cnt  <= '0;
`ifdef FIFO_SER_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         if ((state == IDLE) || baud_last) baud_cnt <= '0;
         else                              baud_cnt <= baud_cnt + BW'(1);
         if (state == DATA) begin
            if (baud_last) bit_idx <= (bit_idx == IW'(W - 1)) ? '0 : bit_idx + IW'(1);
         end else begin
            bit_idx <= '0;
         end
         shreg <= shreg_nxt;
         tx    <= tx_nxt;
         busy  <= (state_nxt != IDLE);
         if (pop) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
`ifdef FIFO_SER_PARITY_EN
            par_q   <= ^pkt_in;
`endif
         end
      end
   end

endmodule

// File: tb/tb_fifo_pkt_serializer.sv
// Directed bench: a queue-based FWFT FIFO model feeds the serializer and a cycle-level receiver checks every frame bit.
module tb_fifo_pkt_serializer;

   localparam int W     = 10;
   localparam int BD    = 4;
   localparam int CNT_W = 16;
`ifdef FIFO_SER_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif
   localparam int FRAME = NB * BD;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic             empty = 1'b1;
   logic [W-1:0]     pkt_in = '0;
   logic             re, tx, busy;
   logic [CNT_W-1:0] pkt_cnt;

   int checks = 0;
   int errors = 0;
   int frames_done = 0;
   int rx_pos = -1;
   logic [W-1:0] rx_pkt;
   logic         pop_pend = 1'b0;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];

   int re_cnt, busy_cnt, txlow_cnt, busy_runs, first_re, last_re;

   fifo_pkt_serializer #(.W(W), .BAUD_DIV(BD), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .empty   (empty),
      .pkt_in  (pkt_in),
      .re      (re),
      .tx      (tx),
      .busy    (busy),
      .pkt_cnt (pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fifo_outs();
      empty  = (fifo_q.size() == 0);
      pkt_in = empty ? '0 : fifo_q[0];
   endtask

   task automatic push(input logic [W-1:0] v);
      fifo_q.push_back(v);
      exp_q.push_back(v);
      fifo_outs();
   endtask

   function automatic logic frame_bit(input logic [W-1:0] p, input int b);
      if (b == 0)  return 1'b0;
      if (b <= W)  return p[b-1];
`ifdef FIFO_SER_PARITY_EN
      if (b == W + 1) return ^p;
`endif
      return 1'b1;
   endfunction

   // FIFO read port: the head advances on the edge where re was high.
   always @(negedge clk) pop_pend = re;
   always @(posedge clk) begin
      #1;
      if (pop_pend) begin
         chk("fifo_underflow", {31'd0, fifo_q.size() != 0}, 32'd1);
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         fifo_outs();
      end
   end

   // Receiver: each frame is matched against the next packet placed in the FIFO.
   always @(negedge clk) begin
      if (!rst) begin
         rx_pos = -1;
      end else begin
         if (rx_pos < 0 && tx === 1'b0) begin
            rx_pos = 0;
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
               rx_pkt = '0;
            end else begin
               rx_pkt = exp_q.pop_front();
            end
         end
         if (rx_pos >= 0) begin
            chk($sformatf("frame_%0h_pos%0d", rx_pkt, rx_pos), {30'd0, tx, busy},
                {30'd0, frame_bit(rx_pkt, rx_pos / BD), 1'b1});
            rx_pos++;
            if (rx_pos == FRAME) begin
               rx_pos = -1;
               frames_done++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      logic prev_re, prev_busy;
      re_cnt = 0; busy_cnt = 0; txlow_cnt = 0; busy_runs = 0; first_re = -1; last_re = -1;
      prev_re = 1'b0; prev_busy = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         if (prev_re) chk("start_after_pop", {30'd0, tx, busy}, 32'd1);
         if (re) begin
            chk("re_not_empty", {31'd0, empty}, 32'd0);
            if (re_cnt == 0) first_re = i;
            last_re = i;
            re_cnt++;
         end
         if (busy) busy_cnt++;
         if (busy && !prev_busy) busy_runs++;
         if (!tx) txlow_cnt++;
         prev_re = re;
         prev_busy = busy;
         tick();
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      en = 1'b1;
      push(10'h2A5);
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         chk("reset_outs", {29'd0, re, tx, busy}, 32'b010);
         chk("reset_cnt", {16'd0, pkt_cnt}, 32'd0);
      end

      // Single packet straight out of reset.
      tick();
      rst = 1'b1;
      run(FRAME + 12);
      chk("single_re_pulses", re_cnt, 1);
      chk("single_busy_len", busy_cnt, FRAME);
      chk("single_pkt_cnt", {16'd0, pkt_cnt}, 1);
      chk("single_frames", frames_done, 1);

      // Empty FIFO with enable high.
      run(100);
      chk("idle_re", re_cnt, 0);
      chk("idle_busy", busy_cnt, 0);
      chk("idle_txlow", txlow_cnt, 0);

      // Back-to-back packets.
      push(10'h3FF);
      push(10'h000);
      run(2 * FRAME + 10);
      chk("b2b_re_pulses", re_cnt, 2);
      chk("b2b_re_spacing", last_re - first_re, FRAME);
      chk("b2b_busy_len", busy_cnt, 2 * FRAME);
      chk("b2b_busy_runs", busy_runs, 1);
      chk("b2b_pkt_cnt", {16'd0, pkt_cnt}, 3);
      chk("b2b_frames", frames_done, 3);

      // Enable dropped mid-frame.
      push(10'h155);
      run(11);
      chk("en_first_pop", re_cnt, 1);
      en = 1'b0;
      push(10'h0F0);
      run(FRAME + 10);
      chk("en_low_re", re_cnt, 0);
      chk("en_low_frames", frames_done, 4);
      chk("en_low_busy", {31'd0, busy}, 0);
      chk("en_low_pkt_cnt", {16'd0, pkt_cnt}, 4);
      en = 1'b1;
      #1;
      chk("en_return_pop", {31'd0, re}, 1);
      run(FRAME + 5);
      chk("en_return_re", re_cnt, 1);
      chk("en_return_frames", frames_done, 5);
      chk("en_return_pkt_cnt", {16'd0, pkt_cnt}, 5);

      // Reset during data bit 3.
      push(10'h1C3);
      run(17);
      chk("midrst_pop", re_cnt, 1);
      rst = 1'b0;
      #1;
      chk("midrst_outs", {29'd0, re, tx, busy}, 32'b010);
      chk("midrst_cnt", {16'd0, pkt_cnt}, 0);
      push(10'h2B4);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("midrst_hold", {29'd0, re, tx, busy}, 32'b010);
      end
      tick();
      rst = 1'b1;
      run(FRAME + 5);
      chk("postrst_re", re_cnt, 1);
      chk("postrst_frames", frames_done, 6);
      chk("postrst_pkt_cnt", {16'd0, pkt_cnt}, 1);
      chk("exp_queue_drained", exp_q.size(), 0);
      chk("fifo_drained", fifo_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
